clmul_digit_serial: RTL and testbench

- Parametrised digit-serial carry-less (GF(2)[x]) polynomial multiplier.
- Computes the unreduced 2*WIDTH-1 bit product of two WIDTH-bit polynomials. Each cycle it processes DIGIT bits of operand b.
- This is the area-lean, sequential generalisation of our fixed-width combinational carry-less multipliers.
- Intended use is the OBS/Karatsuba partial-product stages up to the 233-bit field. It has valid/ready handshakes on both input and output.

---
 rtl/clmul_digit_serial_if.sv | 24 ++
 rtl/clmul_digit_serial.sv | 122 ++++++++++++
 tb/tb_clmul_digit_serial.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/clmul_digit_serial_if.sv
// Operand/result handshake bundle for the digit-serial carry-less multiplier.
// The master side issues operands and sinks products.
interface clmul_digit_serial_if #(
  parameter int WIDTH = 15
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-2:0] y;
  logic               busy;

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, y, busy
  );

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, y, busy
  );
endinterface

// File: rtl/clmul_digit_serial.sv
// Digit-serial GF(2)[x] multiplier: DIGIT bits of b per cycle, unreduced
// 2*WIDTH-1 bit product, valid/ready on both sides.
module clmul_digit_pp #(
  parameter int WIDTH = 15,
  parameter int DIGIT = 4
) (
  input  logic [WIDTH-1:0]       i_a,
  input  logic [DIGIT-1:0]       i_d,
  output logic [WIDTH+DIGIT-2:0] o_p
);
  localparam int PW = WIDTH + DIGIT - 1;

  logic [PW-1:0] w_ax;

  always_comb begin
    w_ax = '0;
    w_ax[WIDTH-1:0] = i_a;
    o_p = '0;
    for (int j = 0; j < DIGIT; j++)
      if (i_d[j]) o_p = o_p ^ (w_ax << j);
  end
endmodule

module clmul_digit_serial #(
  parameter int WIDTH = 15,
  parameter int DIGIT = 4
) (
  input logic               clk,
  input logic               rst_n,
  clmul_digit_serial_if.slave bus
);
  localparam int NDIG = (WIDTH + DIGIT - 1) / DIGIT;
  localparam int PADW = NDIG * DIGIT;
  localparam int YW   = 2 * WIDTH - 1;
  localparam int PW   = WIDTH + DIGIT - 1;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          r_state, w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [PADW-1:0]  r_b;
  logic [PADW-1:0]  w_b_pad;
  logic [YW-1:0]    r_acc, w_acc_nxt, r_y;
  logic [CW-1:0]    r_cnt;
  logic [PW-1:0]    w_pp;
  logic             w_last;

  // Digits are consumed MSB-first (Horner form): shifting the accumulator
  // left each step lands every partial product at cnt*DIGIT without a
  // variable shifter. Bits shifted past 2*WIDTH-2 are provably zero.
  clmul_digit_pp #(.WIDTH(WIDTH), .DIGIT(DIGIT)) u_pp (
    .i_a (r_a),
    .i_d (r_b[PADW-1 -: DIGIT]),
    .o_p (w_pp)
  );

  assign w_last = (r_cnt == CW'(NDIG - 1));

  always_comb begin
    w_b_pad = '0;
    w_b_pad[WIDTH-1:0] = bus.b;
    w_acc_nxt = r_acc << DIGIT;
    w_acc_nxt[PW-1:0] = w_acc_nxt[PW-1:0] ^ w_pp;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    case (r_state)
      S_IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        bus.busy = 1'b1;
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        bus.busy      = 1'b1;
        bus.out_valid = 1'b1;
        if (bus.out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
      r_cnt <= '0;
      r_y   <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (bus.in_valid) begin
          r_a   <= bus.a;
          r_b   <= w_b_pad;
          r_acc <= '0;
          r_cnt <= '0;
        end
        S_RUN: begin
          r_acc <= w_acc_nxt;
          r_b   <= r_b << DIGIT;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) r_y <= w_acc_nxt;
        end
        default: ;
      endcase
    end
  end

  assign bus.y = r_y;
endmodule

// File: tb/tb_clmul_digit_serial.sv
// Directed checks on a 15/4 instance plus randomized scoreboards on four
// WIDTH/DIGIT configurations against a plain shift-and-xor product.
module tb_clmul_digit_serial;
  localparam int NRAND = 1500;

  typedef logic [1022:0] wide_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, rst_dir_n;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  function automatic wide_t gf_mul(input logic [511:0] a, input logic [511:0] b, input int w);
    wide_t p = '0;
    for (int i = 0; i < w; i++)
      if (b[i]) p = p ^ (wide_t'(a) << i);
    return p;
  endfunction

  function automatic logic [511:0] rnd_vec(input int w);
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
    return v & ((512'b1 << w) - 512'b1);
  endfunction

  task automatic chk(input string nm, input wide_t act, input wide_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: event did not occur as required", nm);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed instance (15/4) ----------------
  clmul_digit_serial_if #(.WIDTH(15)) dif();
  clmul_digit_serial #(.WIDTH(15), .DIGIT(4)) u_dir (
    .clk   (clk),
    .rst_n (rst_dir_n),
    .bus   (dif)
  );

  logic [28:0] dq[$];

  always @(negedge clk) begin
    if (rst_dir_n && dif.out_valid && dif.out_ready) begin
      if (dq.size() == 0) fail_now("dir_unexpected_result");
      else chk("dir_y", wide_t'(dif.y), wide_t'(dq.pop_front()));
    end
  end

  task automatic dir_op(input logic [14:0] a, input logic [14:0] b,
                        input logic [28:0] exp, input bit drain, input string nm);
    int t = 0;
    while (!dif.in_ready && t < 100) begin tick(); t++; end
    if (t >= 100) fail_now({nm, "_idle_wait"});
    dif.a = a; dif.b = b; dif.in_valid = 1'b1;
    dq.push_back(exp);
    tick();
    dif.in_valid = 1'b0;
    dif.a = 15'($urandom);
    dif.b = 15'($urandom);
    chk1({nm, "_in_ready_low"}, dif.in_ready, 1'b0);
    chk1({nm, "_busy"}, dif.busy, 1'b1);
    for (int k = 0; k < 4; k++) begin
      chk1({nm, "_ov_early"}, dif.out_valid, 1'b0);
      tick();
    end
    chk1({nm, "_ov_at_ndig"}, dif.out_valid, 1'b1);
    if (drain) begin
      tick();
      chk1({nm, "_idle_in_ready"}, dif.in_ready, 1'b1);
      chk1({nm, "_idle_ov"}, dif.out_valid, 1'b0);
    end
  endtask

  // ---------------- random instances ----------------
  for (genvar g = 0; g < 4; g++) begin : g_cfg
    localparam int W  = (g == 3) ? 233 : 15;
    localparam int D  = (g == 0) ? 1 : (g == 1) ? 4 : (g == 2) ? 15 : 16;
    localparam int ND = (W + D - 1) / D;

    clmul_digit_serial_if #(.WIDTH(W)) rif();
    clmul_digit_serial #(.WIDTH(W), .DIGIT(D)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (rif)
    );

    wide_t eq[$];
    int    aq[$];
    int    ndone = 0;
    logic  ov_q  = 1'b0;

    initial begin : drv
      logic [511:0] va, vb;
      int t;
      rif.in_valid = 1'b0;
      rif.a = '0;
      rif.b = '0;
      wait (rst_n === 1'b1);
      tick();
      for (int n = 0; n < NRAND; n++) begin
        repeat ($urandom_range(0, 2)) tick();
        va = rnd_vec(W);
        vb = rnd_vec(W);
        case ($urandom_range(0, 9))
          0: va = {512{1'b1}} >> (512 - W);
          1: vb = {512{1'b1}} >> (512 - W);
          2: va = '0;
          3: vb = 512'b1 << (W - 1);
          default: ;
        endcase
        rif.a = va[W-1:0];
        rif.b = vb[W-1:0];
        rif.in_valid = 1'b1;
        t = 0;
        while (!rif.in_ready && t < 400) begin tick(); t++; end
        if (t >= 400) fail_now($sformatf("cfg%0d_accept_timeout", g));
        eq.push_back(gf_mul(va, vb, W));
        aq.push_back(cyc + 1);
        tick();
        rif.in_valid = 1'b0;
      end
    end

    initial begin : bp
      rif.out_ready = 1'b0;
      forever begin
        tick();
        rif.out_ready = ($urandom_range(0, 3) != 0);
      end
    end

    always @(negedge clk) begin
      if (!rst_n) ov_q = 1'b0;
      else begin
        if (rif.out_valid && !ov_q) begin
          if (aq.size() == 0) fail_now($sformatf("cfg%0d_spurious_valid", g));
          else chki($sformatf("cfg%0d_latency", g), cyc - aq.pop_front(), ND);
        end
        ov_q = rif.out_valid;
        if (rif.out_valid && rif.out_ready) begin
          if (eq.size() == 0) fail_now($sformatf("cfg%0d_unexpected_result", g));
          else begin
            chk($sformatf("cfg%0d_y", g), wide_t'(rif.y), eq.pop_front());
            ndone++;
          end
        end
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [28:0] hold_exp;
    int t;
    rst_n = 1'b0;
    rst_dir_n = 1'b0;
    dif.in_valid = 1'b0;
    dif.a = '0;
    dif.b = '0;
    dif.out_ready = 1'b1;
    #3;
    chk1("rst_in_ready", dif.in_ready, 1'b1);
    chk1("rst_out_valid", dif.out_valid, 1'b0);
    chk1("rst_busy", dif.busy, 1'b0);
    chk("rst_y", wide_t'(dif.y), '0);
    tick(); tick();
    rst_n = 1'b1;
    rst_dir_n = 1'b1;
    tick();

    dir_op(15'h0003, 15'h0003, 29'h00000005, 1'b1, "t1");
    dir_op(15'h7FFF, 15'h7FFF, 29'h15555555, 1'b1, "t2_ones");
    dir_op(15'h4000, 15'h4000, 29'h10000000, 1'b1, "t2_top");
    dir_op(15'h0000, 15'h7FFF, 29'h00000000, 1'b1, "t2_zero");

    // backpressure: result must hold while new operands are offered
    hold_exp = 29'(gf_mul(512'h1234, 512'h0ABC, 15));
    dif.out_ready = 1'b0;
    dir_op(15'h1234, 15'h0ABC, hold_exp, 1'b0, "t3");
    for (int k = 0; k < 10; k++) begin
      dif.in_valid = k[0];
      dif.a = 15'($urandom);
      dif.b = 15'($urandom);
      tick();
      chk("t3_y_hold", wide_t'(dif.y), wide_t'(hold_exp));
      chk1("t3_ov_hold", dif.out_valid, 1'b1);
      chk1("t3_in_ready_low", dif.in_ready, 1'b0);
    end
    dif.in_valid = 1'b0;
    dif.out_ready = 1'b1;
    tick();
    chk1("t3_release_in_ready", dif.in_ready, 1'b1);
    chk1("t3_release_ov", dif.out_valid, 1'b0);
    chk1("t3_release_busy", dif.busy, 1'b0);
    dir_op(15'h0005, 15'h0003, 29'h0000000F, 1'b1, "t3_next");

    // reset abort at cnt=2
    dif.a = 15'h7FFF; dif.b = 15'h1234; dif.in_valid = 1'b1;
    tick();
    dif.in_valid = 1'b0;
    tick(); tick();
    #2 rst_dir_n = 1'b0;
    #1;
    chk1("t4_rst_in_ready", dif.in_ready, 1'b1);
    chk1("t4_rst_ov", dif.out_valid, 1'b0);
    chk1("t4_rst_busy", dif.busy, 1'b0);
    chk("t4_rst_y", wide_t'(dif.y), '0);
    @(posedge clk);
    #3 rst_dir_n = 1'b1;
    tick();
    dir_op(15'h0005, 15'h0007, 29'h0000001B, 1'b1, "t4");

    t = 0;
    while ((g_cfg[0].ndone < NRAND || g_cfg[1].ndone < NRAND ||
            g_cfg[2].ndone < NRAND || g_cfg[3].ndone < NRAND) && t < 90000) begin
      tick();
      t++;
    end
    if (t >= 90000) fail_now("random_sweep_timeout");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
